// File: rtl/du_program_loader_pkg.sv
// Shared constants and state encoding for the debug-unit program loader.
package du_program_loader_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  function automatic logic is_halt(input logic [5:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/du_word_assembler.sv
// Packs a UART byte stream MSB-first into instruction words; the completed
// word and its valid flag are presented in the same cycle as the last byte.
module du_word_assembler #(
  parameter int NB_INST = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clock,
  input  logic               i_reset_n,
  input  logic [NB_BYTE-1:0] i_byte,
  input  logic               i_strobe,
  input  logic               i_clear,
  output logic [NB_INST-1:0] o_word,
  output logic               o_word_valid
);

  localparam int NBYTES = NB_INST / NB_BYTE;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  logic [NB_INST-1:0] word_r;
  logic [CW-1:0]      cnt;

  // Exposing the shifted word combinationally lets the top register it
  // straight into the write port on the edge that captures the last byte.
  assign o_word       = {word_r[NB_INST-NB_BYTE-1:0], i_byte};
  assign o_word_valid = i_strobe && !i_clear && (cnt == LAST);

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      word_r <= '0;
      cnt    <= '0;
    end else if (i_clear) begin
      word_r <= '0;
      cnt    <= '0;
    end else if (i_strobe) begin
      word_r <= o_word;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/du_program_loader.sv
// UART-driven instruction loader: L loads words until HALT (or memory full),
// R runs the pipeline until it reports halt.
module du_program_loader
  import du_program_loader_pkg::*;
#(
  parameter int ADDRWIDTH = 8,
  parameter int NB_INST   = 32,
  parameter int NB_BYTE   = 8
) (
  input  logic                 clock,
  input  logic                 i_reset_n,
  input  logic [NB_BYTE-1:0]   i_rx_data,
  input  logic                 i_rx_done,
  input  logic                 i_halt,
  output logic [NB_INST-1:0]   o_inst_load,
  output logic [ADDRWIDTH-1:0] o_addr_inst_load,
  output logic                 o_en_write,
  output logic                 o_debug_unit,
  output logic                 o_enable_pipe,
  output logic                 o_en_read,
  output logic                 o_load_done,
  output logic                 o_overflow
);

  localparam logic [ADDRWIDTH-1:0] ADDR_MAX = {ADDRWIDTH{1'b1}};

  state_e               state, state_n;
  logic [ADDRWIDTH-1:0] addr_n;
  logic [NB_INST-1:0]   inst_n;
  logic                 wr_n, dbg_n, en_n, done_n, ovf_n;
  logic                 asm_clear;
  logic [NB_INST-1:0]   asm_word;
  logic                 asm_valid;

  du_word_assembler #(
    .NB_INST (NB_INST),
    .NB_BYTE (NB_BYTE)
  ) u_asm (
    .clock        (clock),
    .i_reset_n    (i_reset_n),
    .i_byte       (i_rx_data),
    .i_strobe     (i_rx_done),
    .i_clear      (asm_clear),
    .o_word       (asm_word),
    .o_word_valid (asm_valid)
  );

  always_comb begin
    state_n   = state;
    addr_n    = o_addr_inst_load;
    inst_n    = '0;
    wr_n      = 1'b0;
    dbg_n     = o_debug_unit;
    en_n      = 1'b0;
    done_n    = o_load_done;
    ovf_n     = o_overflow;
    asm_clear = 1'b1;
    case (state)
      ST_IDLE: begin
        if (i_rx_done && i_rx_data == CMD_LOAD) begin
          state_n = ST_LOAD;
          addr_n  = '0;
          done_n  = 1'b0;
          ovf_n   = 1'b0;
          dbg_n   = 1'b1;
        end else if (i_rx_done && i_rx_data == CMD_RUN && o_load_done) begin
          state_n = ST_RUN;
          en_n    = 1'b1;
        end
      end
      ST_LOAD: begin
        asm_clear = 1'b0;
        if (asm_valid) begin
          state_n = ST_WRITE;
          wr_n    = 1'b1;
          inst_n  = asm_word;
        end
      end
      ST_WRITE: begin
        // Assembler stays live so a byte landing here starts the next word.
        asm_clear = 1'b0;
        if (is_halt(o_inst_load[NB_INST-1 -: 6])) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
          dbg_n   = 1'b0;
          addr_n  = o_addr_inst_load + 1'b1;
        end else if (o_addr_inst_load == ADDR_MAX) begin
          state_n = ST_IDLE;
          ovf_n   = 1'b1;
          dbg_n   = 1'b0;
        end else begin
          state_n = ST_LOAD;
          addr_n  = o_addr_inst_load + 1'b1;
        end
      end
      ST_RUN: begin
        en_n = !i_halt;
        if (i_halt) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state            <= ST_IDLE;
      o_inst_load      <= '0;
      o_addr_inst_load <= '0;
      o_en_write       <= 1'b0;
      o_debug_unit     <= 1'b0;
      o_enable_pipe    <= 1'b0;
      o_en_read        <= 1'b0;
      o_load_done      <= 1'b0;
      o_overflow       <= 1'b0;
    end else begin
      state            <= state_n;
      o_inst_load      <= inst_n;
      o_addr_inst_load <= addr_n;
      o_en_write       <= wr_n;
      o_debug_unit     <= dbg_n;
      o_enable_pipe    <= en_n;
      o_en_read        <= en_n;
      o_load_done      <= done_n;
      o_overflow       <= ovf_n;
    end
  end

endmodule

// File: tb/tb_du_program_loader.sv
// Directed bench for du_program_loader; memory writes are checked by a
// scoreboard monitor, status flags by inline checks.
module tb_du_program_loader;

  localparam int AW = 2;

  logic          clock = 1'b0;
  logic          i_reset_n;
  logic [7:0]    i_rx_data;
  logic          i_rx_done;
  logic          i_halt;
  logic [31:0]   o_inst_load;
  logic [AW-1:0] o_addr_inst_load;
  logic          o_en_write, o_debug_unit, o_enable_pipe, o_en_read;
  logic          o_load_done, o_overflow;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  vecs = 0;
  int  errs = 0;
  int  nwr  = 0;

  du_program_loader #(.ADDRWIDTH(AW), .NB_INST(32), .NB_BYTE(8)) dut (
    .clock            (clock),
    .i_reset_n        (i_reset_n),
    .i_rx_data        (i_rx_data),
    .i_rx_done        (i_rx_done),
    .i_halt           (i_halt),
    .o_inst_load      (o_inst_load),
    .o_addr_inst_load (o_addr_inst_load),
    .o_en_write       (o_en_write),
    .o_debug_unit     (o_debug_unit),
    .o_enable_pipe    (o_enable_pipe),
    .o_en_read        (o_en_read),
    .o_load_done      (o_load_done),
    .o_overflow       (o_overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  // Scoreboard monitor: every write pulse must match the next expected write.
  always @(negedge clock) begin
    if (o_en_write) begin
      wr_t e;
      nwr++;
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_write: addr=%0h data=%08h, required no write",
                 o_addr_inst_load, o_inst_load);
      end else begin
        e = exp_q.pop_front();
        if (o_addr_inst_load !== e.addr || o_inst_load !== e.data) begin
          errs++;
          $display("FAIL write: addr=%0h data=%08h, required addr=%0h data=%08h",
                   o_addr_inst_load, o_inst_load, e.addr, e.data);
        end
      end
    end else if (o_inst_load !== 32'h0) begin
      vecs++;
      errs++;
      $display("FAIL inst_idle: o_inst_load=%08h outside write, required 0", o_inst_load);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; the byte is sampled by the next rising edge.
  task automatic send(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge clock);
    i_rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) begin
      send(w[k*8 +: 8]);
      idle(1);
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en_write"},   o_en_write,       0);
    chk({tag, "_addr"},       o_addr_inst_load, 0);
    chk({tag, "_debug"},      o_debug_unit,     0);
    chk({tag, "_enable"},     o_enable_pipe,    0);
    chk({tag, "_en_read"},    o_en_read,        0);
    chk({tag, "_load_done"},  o_load_done,      0);
    chk({tag, "_overflow"},   o_overflow,       0);
  endtask

  initial begin
    int w0;
    logic [7:0] bb [8];
    i_reset_n = 1'b0;
    i_rx_data = 8'h0;
    i_rx_done = 1'b0;
    i_halt    = 1'b0;
    idle(3);
    chk_all_zero("reset");
    i_reset_n = 1'b1;
    idle(2);

    // Run before load, and a stray byte in IDLE
    send(8'h52); idle(2);
    chk("run_before_load_en", o_enable_pipe, 0);
    chk("run_before_load_rd", o_en_read, 0);
    send(8'h00); idle(2);
    chk("idle_byte_debug", o_debug_unit, 0);
    chk("idle_byte_done", o_load_done, 0);

    // Two-word program with HALT
    push(0, 32'h3C01000A);
    push(1, 32'hFC000000);
    send(8'h4C);
    chk("load_debug_set", o_debug_unit, 1);
    idle(1);
    send_word(32'h3C01000A);
    send_word(32'hFC000000);
    chk("prog_done", o_load_done, 1);
    chk("prog_debug_clr", o_debug_unit, 0);
    chk("prog_len", o_addr_inst_load, 2);
    chk("prog_nwr", nwr, 2);
    chk("prog_q_empty", exp_q.size(), 0);

    // Run and halt, then re-run
    send(8'h52);
    chk("run_en", o_enable_pipe, 1);
    chk("run_rd", o_en_read, 1);
    send(8'h4C); idle(1);
    chk("run_ignores_L", o_debug_unit, 0);
    chk("run_still_en", o_enable_pipe, 1);
    i_halt = 1'b1; idle(1); i_halt = 1'b0;
    chk("halt_en", o_enable_pipe, 0);
    chk("halt_rd", o_en_read, 0);
    chk("halt_done_kept", o_load_done, 1);
    idle(1);
    send(8'h52);
    chk("rerun_en", o_enable_pipe, 1);
    chk("rerun_rd", o_en_read, 1);
    i_halt = 1'b1; idle(1); i_halt = 1'b0;
    chk("rehalt_en", o_enable_pipe, 0);

    // Overflow: 2^AW words, none of them HALT
    for (int a = 0; a < 4; a++) push(AW'(a), 32'h0);
    send(8'h4C);
    chk("ovf_L_clears_done", o_load_done, 0);
    idle(1);
    for (int k = 0; k < 4; k++) send_word(32'h0);
    chk("ovf_flag", o_overflow, 1);
    chk("ovf_done", o_load_done, 0);
    chk("ovf_debug", o_debug_unit, 0);
    chk("ovf_nwr", nwr, 6);
    send_word(32'h0);
    chk("ovf_extra_nwr", nwr, 6);
    chk("ovf_extra_debug", o_debug_unit, 0);
    send(8'h52); idle(1);
    chk("ovf_run_blocked", o_enable_pipe, 0);

    // Back-to-back strobes, byte 5 lands during WRITE
    bb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFC, 8'h00, 8'h00, 8'hAA};
    push(0, 32'h11223344);
    push(1, 32'hFC0000AA);
    send(8'h4C);
    chk("b2b_ovf_cleared", o_overflow, 0);
    idle(1);
    for (int k = 0; k < 8; k++) send(bb[k]);
    idle(1);
    chk("b2b_done", o_load_done, 1);
    chk("b2b_nwr", nwr, 8);
    chk("b2b_q_empty", exp_q.size(), 0);

    // Reset in the middle of a word
    send(8'h4C); idle(1);
    send(8'h20); idle(1);
    send(8'h00);
    i_reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    idle(2);
    i_reset_n = 1'b1;
    idle(2);
    chk("midrst_nwr", nwr, 8);
    push(0, 32'h2000030A);
    send(8'h4C); idle(1);
    send_word(32'h2000030A);
    chk("midrst_nwr_after", nwr, 9);
    chk("midrst_addr", o_addr_inst_load, 1);
    chk("midrst_debug", o_debug_unit, 1);
    chk("midrst_done", o_load_done, 0);
    w0 = exp_q.size();
    chk("final_q_empty", w0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
